// File: rtl/octspi_host.sv
// octspi_host: octal-SPI SDR initiator; bus clock is clk/2; frame = cmd,size,addr[23:0] header then data.
// Optional OSPI_HOST_WR_TIMEOUT_EN: abort a write frame starved of data for WR_TIMEOUT clk.
module octspi_host #(
  parameter int DMY_LEN    = 2,
  parameter int RD_LAT     = 1,
  parameter int NCS_GAP    = 4,
  parameter int WR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_size,
  input  logic [23:0] cmd_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        err,
  output logic        ospi_ncs,
  output logic        ospi_sclk,
  output logic [7:0]  ospi_dq_o,
  output logic        ospi_dq_oe,
  input  logic [7:0]  ospi_dq_i
);

  typedef enum logic [2:0] {IDLE, HDR, DUMMY, DATA, TAIL, GAP} state_t;

  localparam logic [7:0] DWAIT_LAST = 8'(DMY_LEN + RD_LAT - 1);
  localparam logic [7:0] GAP_LAST   = 8'(NCS_GAP - 1);

  state_t      state, state_n;
  logic        phase, phase_n;  // 0 = phase L (sclk low), 1 = phase H
  logic        armed;           // holds cmd_ready low for the first clk out of reset
  logic [7:0]  idx, idx_n;
  logic [7:0]  dq_q, dq_n, hdr_next, size_q, rd_data_n;
  logic        wr_q, rd_valid_n, accept;
  logic [23:0] addr_q;

`ifdef OSPI_HOST_WR_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(WR_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_n;
  logic       err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready  = armed && (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE);
  assign ospi_ncs   = !(state inside {HDR, DUMMY, DATA, TAIL});
  assign ospi_sclk  = phase;
  assign ospi_dq_oe = (state == HDR) || (state == DATA && wr_q);

  always_comb begin
    case (idx)
      8'd0:    hdr_next = size_q;
      8'd1:    hdr_next = addr_q[23:16];
      8'd2:    hdr_next = addr_q[15:8];
      default: hdr_next = addr_q[7:0];
    endcase
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    idx_n      = idx;
    dq_n       = dq_q;
    rd_valid_n = 1'b0;
    rd_data_n  = rd_data;
    wr_ready   = 1'b0;
    ospi_dq_o  = dq_q;
`ifdef OSPI_HOST_WR_TIMEOUT_EN
    tmo_n      = tmo_q;
    err_n      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = HDR;
          phase_n = 1'b0;
          idx_n   = 8'd0;
          dq_n    = cmd_write ? 8'hA0 : 8'h20;
`ifdef OSPI_HOST_WR_TIMEOUT_EN
          tmo_n   = 8'd0;
`endif
        end
      end
      HDR: begin
        phase_n = ~phase;
        if (phase) begin
          if (idx == 8'd4) begin
            idx_n = 8'd0;
            dq_n  = 8'd0;
            if (!wr_q)              state_n = DUMMY;
            else if (size_q != 8'd0) state_n = DATA;
            else                     state_n = TAIL;
          end else begin
            idx_n = idx + 8'd1;
            dq_n  = hdr_next;
          end
        end
      end
      DUMMY: begin
        phase_n = ~phase;
        if (phase) begin
          if (idx == DWAIT_LAST) begin
            idx_n   = 8'd0;
            state_n = (size_q != 8'd0) ? DATA : TAIL;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      DATA: begin
        if (phase) begin
          phase_n = 1'b0;
          if (idx == size_q - 8'd1) begin
            idx_n   = 8'd0;
            dq_n    = 8'd0;
            state_n = TAIL;
          end else begin
            idx_n = idx + 8'd1;
          end
        end else if (!wr_q) begin
          // this edge raises sclk: capture the target's byte now
          rd_valid_n = 1'b1;
          rd_data_n  = ospi_dq_i;
          phase_n    = 1'b1;
        end else if (wr_valid) begin
          wr_ready  = 1'b1;
          ospi_dq_o = wr_data;
          dq_n      = wr_data;
          phase_n   = 1'b1;
`ifdef OSPI_HOST_WR_TIMEOUT_EN
          tmo_n     = 8'd0;
`endif
        end else begin
          // starved: sclk stays low, stretching the bus cycle
`ifdef OSPI_HOST_WR_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            err_n   = 1'b1;
            state_n = GAP;
            idx_n   = 8'd0;
            dq_n    = 8'd0;
          end else begin
            tmo_n = tmo_q + 8'd1;
          end
`endif
        end
      end
      TAIL: begin
        phase_n = ~phase;
        if (phase) begin
          state_n = GAP;
          idx_n   = 8'd0;
        end
      end
      GAP: begin
        if (idx == GAP_LAST) begin
          state_n = IDLE;
          idx_n   = 8'd0;
        end else begin
          idx_n = idx + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= 1'b0;
      armed    <= 1'b0;
      idx      <= 8'd0;
      dq_q     <= 8'd0;
      wr_q     <= 1'b0;
      size_q   <= 8'd0;
      addr_q   <= 24'd0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      armed    <= 1'b1;
      idx      <= idx_n;
      dq_q     <= dq_n;
      rd_valid <= rd_valid_n;
      rd_data  <= rd_data_n;
      if (accept) begin
        wr_q   <= cmd_write;
        size_q <= cmd_size;
        addr_q <= cmd_addr;
      end
    end
  end

`ifdef OSPI_HOST_WR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_n;
      err_q <= err_n;
    end
  end
`endif

endmodule

// File: tb/tb_octspi_host.sv
// Bench for octspi_host: random frames against a frame-level expectation model and an OctoSPI target model.
module tb_octspi_host;
  localparam int NCS_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready;
  logic [7:0]  cmd_size, wr_data, rd_data, ospi_dq_o, ospi_dq_i;
  logic [23:0] cmd_addr;
  logic        rd_valid, busy, err, ospi_ncs, ospi_sclk, ospi_dq_oe;

  octspi_host #(.DMY_LEN(2), .RD_LAT(1), .NCS_GAP(NCS_GAP), .WR_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err),
    .ospi_ncs(ospi_ncs), .ospi_sclk(ospi_sclk), .ospi_dq_o(ospi_dq_o),
    .ospi_dq_oe(ospi_dq_oe), .ospi_dq_i(ospi_dq_i));

  int checks = 0, passes = 0;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // reference memory (what the requester wrote) and the target's own memory
  logic [7:0] ref_mem[256];
  logic [7:0] tgt_mem[256];
  logic [7:0] wbuf[256];

  // expected frame
  int         exp_n, exp_wr;
  logic [7:0] exp_b[300];
  bit         exp_oe[300];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_log[$];
  bit         skip_frame = 0, expect_err = 0;

  // captured frame (one entry per rising sclk)
  int         cap_n = 0, wr_hs = 0, gap_cnt = 0;
  logic [7:0] cap_b[300];
  bit         cap_oe[300];
  bit         gap_valid = 0;
  logic       prev_sclk = 0, prev_ncs = 1;

  function automatic logic [7:0] tgt_idx(input int k);
    return 8'(int'(cap_b[4]) + k);
  endfunction

  // monitor, target model and per-cycle compare
  always begin
    @(negedge clk);
    #2;
    if (!reset_n) begin
      cap_n = 0; wr_hs = 0; gap_valid = 0; prev_sclk = 0; prev_ncs = 1;
      ospi_dq_i = 8'h00;
    end else begin
      if (!ospi_ncs) begin
        if (prev_ncs) begin
          if (gap_valid) chk("ncs_gap_min", int'(gap_cnt >= NCS_GAP), 1);
          cap_n = 0; wr_hs = 0;
        end
        chk("busy_in_frame", busy, 1);
        if (ospi_sclk && !prev_sclk) begin
          if (cap_n < 300) begin cap_b[cap_n] = ospi_dq_o; cap_oe[cap_n] = ospi_dq_oe; end
          cap_n++;
          if (cap_n > 5 && cap_b[0] == 8'hA0 && (cap_n - 6) < int'(cap_b[1]))
            tgt_mem[tgt_idx(cap_n - 6)] = ospi_dq_o;
        end
      end else begin
        if (!prev_ncs) begin
          if (!skip_frame) begin
            chk("frame_sclk_count", cap_n, exp_n);
            for (int i = 0; i < cap_n && i < exp_n && i < 300; i++) begin
              chk("frame_oe", cap_oe[i], exp_oe[i]);
              if (exp_oe[i]) chk("frame_byte", cap_b[i], exp_b[i]);
            end
            chk("frame_wr_handshakes", wr_hs, exp_wr);
            chk("frame_rd_missing", exp_rd.size(), 0);
          end
          skip_frame = 0; gap_valid = 1; gap_cnt = 1;
        end else if (gap_valid) gap_cnt++;
        if (gap_valid && gap_cnt <= NCS_GAP) chk("busy_in_gap", busy, 1);
      end
      if (wr_ready) begin
        chk("wr_ready_needs_valid", wr_valid, 1);
        chk("wr_ready_sclk_low", ospi_sclk, 0);
        if (wr_valid) wr_hs++;
      end
      if (rd_valid) begin
        chk("rd_valid_expected", int'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
        rd_log.push_back(rd_data);
      end
      if (cmd_ready) chk("cmd_ready_only_idle", busy, 0);
      if (!expect_err) chk("err_quiet", err, 0);
      prev_sclk = ospi_sclk; prev_ncs = ospi_ncs;
      // target drives byte k of a read once 5 header + 3 dummy rising edges have passed
      if (!ospi_ncs && cap_n >= 8 && cap_b[0] == 8'h20) ospi_dq_i = tgt_mem[tgt_idx(cap_n - 8)];
      else ospi_dq_i = 8'($urandom);
    end
  end

  task automatic send_cmd(input bit w, input int size, input logic [23:0] addr);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_size = 8'(size); cmd_addr = addr;
    for (int t = 0; t < 2000; t++) begin
      #1;
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("cmd_accepted", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic issue_cmd(input bit w, input int size, input logic [23:0] addr,
                           input int stall_idx, input int stall_len, input bit rnd);
    int k = 0, consec = 0, left = stall_len, pre;
    pre = w ? 5 : 8;
    exp_n = pre + size + 1;
    exp_wr = w ? size : 0;
    exp_b[0] = w ? 8'hA0 : 8'h20; exp_b[1] = 8'(size);
    exp_b[2] = addr[23:16]; exp_b[3] = addr[15:8]; exp_b[4] = addr[7:0];
    for (int i = 0; i < exp_n; i++) exp_oe[i] = (i < 5);
    for (int i = 0; i < size; i++) begin
      exp_oe[pre + i] = w;
      exp_b[pre + i]  = wbuf[i];
      if (w) ref_mem[8'(int'(addr[7:0]) + i)] = wbuf[i];
      else exp_rd.push_back(ref_mem[8'(int'(addr[7:0]) + i)]);
    end
    send_cmd(w, size, addr);
    if (w) begin
      for (int t = 0; t < 5000 && k < size; t++) begin
        @(negedge clk);
        if (k == stall_idx && left > 0) begin wr_valid = 0; left--; end
        else if (rnd && consec < 3 && $urandom_range(0, 99) < 25) begin wr_valid = 0; consec++; end
        else begin
          wr_valid = 1; wr_data = wbuf[k]; consec = 0;
          #1;
          if (wr_ready) k++;
        end
      end
      chk("wr_bytes_consumed", k, size);
      @(negedge clk);
      wr_valid = 0;
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk); #2;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("frame_completes", busy, 0);
  endtask

  logic [7:0] lit_wr[9] = '{8'hA0, 8'h04, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] lit_rd[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int got, found, sz;
    bit w;
    reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0;
    wr_valid = 0; wr_data = 0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 8'($urandom); tgt_mem[i] = ref_mem[i]; end
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ncs", ospi_ncs, 1);      chk("rst_sclk", ospi_sclk, 0);
    chk("rst_oe", ospi_dq_oe, 0);     chk("rst_dq_o", ospi_dq_o, 0);
    chk("rst_cmd_ready", cmd_ready, 0); chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);         chk("rst_err", err, 0);
    @(negedge clk); reset_n = 1;

    // directed write 11,22,33,44 @0x10, data always valid
    for (int i = 0; i < 4; i++) wbuf[i] = lit_rd[i];
    issue_cmd(1, 4, 24'h000010, -1, 0, 0); wait_idle();
    chk("lit_wr_ncs_sclks", cap_n, 10);
    for (int i = 0; i < 9; i++) chk("lit_wr_byte", cap_b[i], lit_wr[i]);

    // directed read back of the same four bytes
    rd_log.delete();
    issue_cmd(0, 4, 24'h000010, -1, 0, 0); wait_idle();
    chk("lit_rd_ncs_sclks", cap_n, 13);
    chk("lit_rd_cmd", cap_b[0], 8'h20);
    chk("lit_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("lit_rd_byte", rd_log[i], lit_rd[i]);

    // write of 3 with a 6-clk stall before byte 2
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h7E;
    issue_cmd(1, 3, 24'h0000F0, 2, 6, 0); wait_idle();
    chk("stall_ncs_sclks", cap_n, 9);

    // zero-length frames
    issue_cmd(0, 0, 24'h123456, -1, 0, 0); wait_idle();
    chk("rd0_ncs_sclks", cap_n, 9);
    issue_cmd(1, 0, 24'h654321, -1, 0, 0); wait_idle();
    chk("wr0_ncs_sclks", cap_n, 6);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 9);
      for (int k = 0; k < sz; k++) wbuf[k] = 8'($urandom);
      issue_cmd(w, sz, 24'($urandom), -1, 0, 1);
      wait_idle();
    end

    // reset in the middle of a 16-byte read
    rd_log.delete();
    issue_cmd(0, 16, 24'h000020, -1, 0, 0);
    for (int t = 0; t < 500 && rd_log.size() < 3; t++) @(negedge clk);
    chk("rst_mid_reached_data", int'(rd_log.size() >= 3), 1);
    @(negedge clk); reset_n = 0;
    @(negedge clk); #2;
    chk("rst_mid_ncs", ospi_ncs, 1);  chk("rst_mid_oe", ospi_dq_oe, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0); chk("rst_mid_busy", busy, 0);
    exp_rd.delete();
    @(negedge clk); reset_n = 1;
    wbuf[0] = 8'hBE; wbuf[1] = 8'hEF;
    issue_cmd(1, 2, 24'h000030, -1, 0, 0); wait_idle();
    chk("post_rst_ncs_sclks", cap_n, 8);

`ifdef OSPI_HOST_WR_TIMEOUT_EN
    skip_frame = 1; expect_err = 1;
    send_cmd(1, 4, 24'h000040);
    got = 0;
    for (int t = 0; t < 200 && got < 2; t++) begin
      @(negedge clk); wr_valid = 1; wr_data = 8'h5A;
      #1;
      if (wr_ready) got++;
    end
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); wr_valid = 0;
      #2;
      if (err) begin found = k; break; end
    end
    chk("tmo_err_clk", found, 10);
    chk("tmo_ncs_high", ospi_ncs, 1);
    chk("tmo_oe_off", ospi_dq_oe, 0);
    @(negedge clk); #2;
    chk("tmo_err_pulse", err, 0);
    wait_idle();
    expect_err = 0;
    wbuf[0] = 8'h99;
    issue_cmd(1, 1, 24'h000050, -1, 0, 0); wait_idle();
    chk("tmo_next_ncs_sclks", cap_n, 7);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/octspi_host.md
Name: octspi_host

Overview:
- Octal-SPI initiator (SDR, one byte per bus clock) that drives the same framed protocol our OctoSPI RAM target responds to.
- Frame: ncs low, then 5 header bytes: cmd, size, addr[23:16], addr[15:8], addr[7:0].
- Write (cmd 0xA0): then size data bytes. Read (cmd 0x20): then 2 dummy cycles, then size data bytes.
- Sits between an on-chip requester (valid/ready command and write streams, read stream) and the octal pins. Bus clock is generated as clk/2.

Parameters:
- DMY_LEN, 2, dummy bus cycles after the header on reads.
- RD_LAT, 1, extra bus cycles after the dummies before the first valid read byte.
- NCS_GAP, 4, minimum clk cycles ncs stays high between frames.
- WR_TIMEOUT, 255, clk cycles of write-data starvation before abort (only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_write  in  1  1 = write (0xA0), 0 = read (0x20).
- cmd_size  in  8  data byte count, 0..255.
- cmd_addr  in  24  start address.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  write byte consumed.
- wr_data  in  8  write byte.
- rd_valid  out  1  one-clk pulse, read byte valid; no backpressure.
- rd_data  out  8  read byte.
- busy  out  1  frame in progress, including the gap.
- err  out  1  one-clk pulse on abort.
- ospi_ncs  out  1  chip select, active low.
- ospi_sclk  out  1  bus clock.
- ospi_dq_o  out  8  data out.
- ospi_dq_oe  out  1  1 = host drives dq.
- ospi_dq_i  in  8  data in.

Behaviour:
- Reset values: ospi_ncs=1, ospi_sclk=0, ospi_dq_oe=0, ospi_dq_o=0, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, err=0, state=IDLE.
- Reset has priority and aborts any frame: ncs returns high on the next clk.
- Bus cycle = 2 clk:
  - Phase L: sclk=0; host updates dq_o.
  - Phase H: sclk=1.
  - The target samples on the sclk rising edge. The host samples dq_i on the clk edge that drives sclk 0->1.
- States: IDLE, HDR, DUMMY, DATA, TAIL, GAP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch cmd/size/addr, ncs=0 on the next clk, go to HDR with byte index 0.
- HDR:
  - 5 bus cycles, oe=1, bytes in order cmd, size, addr[23:16], addr[15:8], addr[7:0].
  - Then: read -> DUMMY; write with size!=0 -> DATA; size==0 -> TAIL.
- DUMMY (read only):
  - oe=0 for DMY_LEN+RD_LAT bus cycles.
  - Then DATA, or TAIL if size==0.
- DATA, write:
  - Each bus cycle needs one byte. wr_ready=1 for one clk in phase L when wr_valid=1; the byte appears on dq_o that phase.
  - If wr_valid=0, stay in phase L with sclk held low (stretched bus clock); ncs stays low.
- DATA, read:
  - oe=0. Sample dq_i at each sampling edge; rd_valid pulses the next clk with rd_data.
  - Exactly size pulses.
- Byte counter: 8 bits, counts to size. Wrap-around of the target address is the target's concern; the host does not check it.
- TAIL:
  - One extra bus cycle with ncs=0, oe=0, no data. Required so the target's frame counters return to zero.
  - Then ncs=1 and go to GAP.
- GAP:
  - ncs=1, sclk=0 for NCS_GAP clk. Then IDLE.
  - cmd_ready is 0 in every state except IDLE. A back-to-back command is accepted on the first IDLE clk.
- busy=1 in every state except IDLE.

Optional Feature:
- OSPI_HOST_WR_TIMEOUT_EN defined:
  - In write DATA, count consecutive clk with wr_valid=0 while a byte is needed.
  - On reaching WR_TIMEOUT: pulse err, set oe=0, skip TAIL, set ncs=1, go to GAP.
  - The counter clears on each accepted byte.
- Not defined: stalls indefinitely, and err is tied to 0.

Test Plan:
- Write cmd_addr=0x000010, size=4, data 11,22,33,44 always valid -> dq_o bytes A0,04,00,00,10,11,22,33,44 on 9 consecutive rising sclk, then 1 TAIL sclk; ncs low for exactly 10 sclk; then ncs high >=4 clk.
- Read addr 0x000010 size=4 against the target model preloaded 11..44 -> header 20,04,00,00,10; oe=0 for 3 bus cycles; rd_valid pulses 4 times with 11,22,33,44.
- Write size=3 with wr_valid low for 6 clk before byte 2 -> sclk held low during the stall, no extra rising edges, correct bytes; frame completes with no err.
- size=0 read and size=0 write -> header only, then TAIL, then ncs high; no rd_valid, no wr_ready.
- Assert reset_n=0 mid-DATA of a 16-byte read -> next clk ncs=1, oe=0, cmd_ready=0, busy=0. After release, a new 2-byte write completes correctly.
- With OSPI_HOST_WR_TIMEOUT_EN and WR_TIMEOUT=8: starve wr_valid mid-write -> err pulse after 8 clk, ncs high, then IDLE accepts the next command.
